// File: rtl/pipe_control_pkg.sv
// Shared constants and types for the Y86-64 pipeline controller:
// status codes, icodes, the "no register" id, sequencer states and
// the bundle of hazard terms passed from hazard_detect to the top.
package pipe_control_pkg;

    localparam logic [1:0] STAT_INS = 2'b00;
    localparam logic [1:0] STAT_AOK = 2'b01;
    localparam logic [1:0] STAT_HLT = 2'b10;
    localparam logic [1:0] STAT_ADR = 2'b11;

    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] RNONE    = 4'hF;

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_DRAIN = 2'b01,
        ST_HALT  = 2'b10
    } seq_state_e;

    typedef struct packed {
        logic lu;   // load/use: decode needs a value still being loaded
        logic mp;   // conditional jump in execute was not taken
        logic rt;   // ret somewhere in D/E/M
        logic exc;  // non-AOK status in memory or write-back
    } hazard_t;

endpackage

// File: rtl/pipe_control_hazard_detect.sv
// Purely combinational hazard classification for the current cycle.
module hazard_detect
    import pipe_control_pkg::*;
(
    input  logic [3:0] D_icode_i,
    input  logic [3:0] d_srcA_i,
    input  logic [3:0] d_srcB_i,
    input  logic [3:0] E_icode_i,
    input  logic [3:0] E_dstM_i,
    input  logic       e_cnd_i,
    input  logic [3:0] M_icode_i,
    input  logic [1:0] m_stat_i,
    input  logic [1:0] W_stat_i,
    output hazard_t    haz_o
);

    logic e_is_load;

    // Derive the four hazard terms from the stage registers.
    always_comb begin
        e_is_load = (E_icode_i == I_MRMOVQ) || (E_icode_i == I_POPQ);
        haz_o     = '0;
        // RNONE on E_dstM never matches, even if a source is also RNONE.
        haz_o.lu  = e_is_load && (E_dstM_i != RNONE) &&
                    ((E_dstM_i == d_srcA_i) || (E_dstM_i == d_srcB_i));
        haz_o.mp  = (E_icode_i == I_JXX) && !e_cnd_i;
        haz_o.rt  = (D_icode_i == I_RET) || (E_icode_i == I_RET) ||
                    (M_icode_i == I_RET);
        haz_o.exc = (m_stat_i != STAT_AOK) || (W_stat_i != STAT_AOK);
    end

endmodule

// File: rtl/pipe_control.sv
// Pipeline hazard/exception controller: stall and bubble generation,
// RUN/DRAIN/HALT shutdown sequencer and saturating performance counters.
module pipe_control
    import pipe_control_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       D_icode,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       E_dstM,
    input  logic             e_cnd,
    input  logic [3:0]       M_icode,
    input  logic [1:0]       m_stat,
    input  logic [1:0]       W_stat,
    output logic             F_stall,
    output logic             D_stall,
    output logic             D_bubble,
    output logic             E_bubble,
    output logic             M_bubble,
    output logic             W_stall,
    output logic             set_cc,
    output logic             halted,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] lu_cnt,
    output logic [CNT_W-1:0] mp_cnt,
    output logic [CNT_W-1:0] ret_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    hazard_t    haz;
    seq_state_e state_q, state_d;
    logic       active;
    logic [CNT_W-1:0] cyc_q, lu_q, mp_q, ret_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic             en);
        // Stick at all-ones instead of wrapping.
        if (en && (v != {CNT_W{1'b1}}))
            return v + CNT_ONE;
        return v;
    endfunction

    hazard_detect u_hazard (
        .D_icode_i (D_icode),
        .d_srcA_i  (d_srcA),
        .d_srcB_i  (d_srcB),
        .E_icode_i (E_icode),
        .E_dstM_i  (E_dstM),
        .e_cnd_i   (e_cnd),
        .M_icode_i (M_icode),
        .m_stat_i  (m_stat),
        .W_stat_i  (W_stat),
        .haz_o     (haz)
    );

    assign active = (state_q == ST_RUN) || (state_q == ST_DRAIN);

    // Sequencer state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_RUN;
        else     state_q <= state_d;
    end

    // Sequencer next state: a write-back fault halts at once, a memory
    // fault first drains so older instructions can retire.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN: begin
                if (W_stat != STAT_AOK)      state_d = ST_HALT;
                else if (m_stat != STAT_AOK) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (W_stat != STAT_AOK)      state_d = ST_HALT;
            end
            ST_HALT:  state_d = ST_HALT;
            default:  state_d = ST_RUN;
        endcase
    end

    // Pipeline register controls; reset overrides with the flush pattern.
    always_comb begin
        F_stall  = haz.lu | haz.rt;
        D_stall  = haz.lu;
        D_bubble = haz.mp | (haz.rt & ~haz.lu);
        E_bubble = haz.mp | haz.lu;
        M_bubble = 1'b0;
        W_stall  = 1'b0;
        set_cc   = (E_icode == I_OPQ) & ~haz.exc;
        halted   = 1'b0;
        if (rst) begin
            F_stall  = 1'b0;
            D_stall  = 1'b0;
            D_bubble = 1'b1;
            E_bubble = 1'b1;
            M_bubble = 1'b1;
            W_stall  = 1'b0;
            set_cc   = 1'b0;
        end else begin
            unique case (state_q)
                ST_DRAIN: begin
                    M_bubble = 1'b1;
                    set_cc   = 1'b0;
                end
                ST_HALT: begin
                    F_stall  = 1'b1;
                    D_stall  = 1'b1;
                    D_bubble = 1'b0;
                    E_bubble = 1'b0;
                    M_bubble = 1'b0;
                    W_stall  = 1'b1;
                    set_cc   = 1'b0;
                    halted   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Performance counters, frozen once halted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_q <= '0;
            lu_q  <= '0;
            mp_q  <= '0;
            ret_q <= '0;
        end else if (active) begin
            cyc_q <= sat_inc(cyc_q, 1'b1);
            lu_q  <= sat_inc(lu_q,  haz.lu);
            mp_q  <= sat_inc(mp_q,  haz.mp);
            ret_q <= sat_inc(ret_q, haz.rt & ~haz.lu);
        end
    end

    assign cyc_cnt = cyc_q;
    assign lu_cnt  = lu_q;
    assign mp_cnt  = mp_q;
    assign ret_cnt = ret_q;

endmodule

// File: tb/tb_pipe_control.sv
// Directed bench for pipe_control: hazards, sequencer, reset and counters.
// Output vector order: {F_stall,D_stall,D_bubble,E_bubble,M_bubble,W_stall,set_cc,halted}
module tb_pipe_control;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode;
    logic       e_cnd;
    logic [1:0] m_stat, W_stat;

    logic F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc, halted;
    logic [31:0] cyc_cnt, lu_cnt, mp_cnt, ret_cnt;

    logic s_F_stall, s_D_stall, s_D_bubble, s_E_bubble, s_M_bubble, s_W_stall, s_set_cc, s_halted;
    logic [3:0] s_cyc, s_lu, s_mp, s_ret;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_cyc, exp_lu, exp_mp, exp_ret;

    always #5 clk = ~clk;

    pipe_control #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst), .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .E_icode(E_icode), .E_dstM(E_dstM), .e_cnd(e_cnd), .M_icode(M_icode),
        .m_stat(m_stat), .W_stat(W_stat), .F_stall(F_stall), .D_stall(D_stall),
        .D_bubble(D_bubble), .E_bubble(E_bubble), .M_bubble(M_bubble), .W_stall(W_stall),
        .set_cc(set_cc), .halted(halted), .cyc_cnt(cyc_cnt), .lu_cnt(lu_cnt),
        .mp_cnt(mp_cnt), .ret_cnt(ret_cnt)
    );

    pipe_control #(.CNT_W(4)) dut_small (
        .clk(clk), .rst(rst), .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .E_icode(E_icode), .E_dstM(E_dstM), .e_cnd(e_cnd), .M_icode(M_icode),
        .m_stat(m_stat), .W_stat(W_stat), .F_stall(s_F_stall), .D_stall(s_D_stall),
        .D_bubble(s_D_bubble), .E_bubble(s_E_bubble), .M_bubble(s_M_bubble), .W_stall(s_W_stall),
        .set_cc(s_set_cc), .halted(s_halted), .cyc_cnt(s_cyc), .lu_cnt(s_lu),
        .mp_cnt(s_mp), .ret_cnt(s_ret)
    );

    wire [7:0]   outs = {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc, halted};
    wire [127:0] cnts = {cyc_cnt, lu_cnt, mp_cnt, ret_cnt};

    task automatic idle();
        D_icode = 4'h0; d_srcA = 4'hF; d_srcB = 4'hF;
        E_icode = 4'h0; E_dstM = 4'hF; e_cnd = 1'b1;
        M_icode = 4'h0; m_stat = 2'b01; W_stat = 2'b01;
    endtask

    // Advance one clock; expected counters follow the hand-stated increments.
    task automatic tick(input bit dlu, input bit dmp, input bit drt, input bit counting);
        @(posedge clk);
        if (counting) begin
            exp_cyc = exp_cyc + 1;
            exp_lu  = exp_lu + 32'(dlu);
            exp_mp  = exp_mp + 32'(dmp);
            exp_ret = exp_ret + 32'(drt);
        end
        #1;
    endtask

    task automatic clear_exp();
        exp_cyc = 0; exp_lu = 0; exp_mp = 0; exp_ret = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        idle();
        #2;
        rst = 1'b0;
        clear_exp();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        clear_exp();
        #3;
        checks++;
        if (outs !== 8'b0011_1000) begin
            errors++; $display("FAIL reset_outs got=%b exp=%b", outs, 8'b0011_1000);
        end
        checks++;
        if (cnts !== 128'h0) begin
            errors++; $display("FAIL reset_cnts got=%h exp=0", cnts);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (outs !== 8'b0) begin
            errors++; $display("FAIL run_idle_outs got=%b exp=%b", outs, 8'b0);
        end
        tick(0, 0, 0, 1);
        checks++;
        if (cnts !== {exp_cyc, exp_lu, exp_mp, exp_ret}) begin
            errors++; $display("FAIL first_cycle_cnts got=%h exp=%h", cnts, {exp_cyc, exp_lu, exp_mp, exp_ret});
        end
    endtask

    task automatic test_opq();
        idle(); E_icode = 4'h6;
        #1;
        checks++;
        if (outs !== 8'b0000_0010) begin
            errors++; $display("FAIL opq_set_cc got=%b exp=%b", outs, 8'b0000_0010);
        end
        tick(0, 0, 0, 1);
    endtask

    task automatic test_load_use();
        idle(); E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3;
        #1;
        checks++;
        if (outs !== 8'b1101_0000) begin
            errors++; $display("FAIL load_use_outs got=%b exp=%b", outs, 8'b1101_0000);
        end
        tick(1, 0, 0, 1);
        checks++;
        if (cnts !== {exp_cyc, exp_lu, exp_mp, exp_ret}) begin
            errors++; $display("FAIL load_use_cnts got=%h exp=%h", cnts, {exp_cyc, exp_lu, exp_mp, exp_ret});
        end
        // Load with no destination must not match sources that are also RNONE.
        idle(); E_icode = 4'hB;
        #1;
        checks++;
        if (outs !== 8'b0) begin
            errors++; $display("FAIL rnone_no_lu got=%b exp=%b", outs, 8'b0);
        end
        tick(0, 0, 0, 1);
    endtask

    task automatic test_mispredict();
        idle(); E_icode = 4'h7; e_cnd = 1'b0; D_icode = 4'h9;
        #1;
        checks++;
        if (outs !== 8'b1011_0000) begin
            errors++; $display("FAIL mispredict_outs got=%b exp=%b", outs, 8'b1011_0000);
        end
        tick(0, 1, 1, 1);
        checks++;
        if (cnts !== {exp_cyc, exp_lu, exp_mp, exp_ret}) begin
            errors++; $display("FAIL mispredict_cnts got=%h exp=%h", cnts, {exp_cyc, exp_lu, exp_mp, exp_ret});
        end
        // Taken jump with ret in M: only the ret bubble remains.
        idle(); E_icode = 4'h7; e_cnd = 1'b1; M_icode = 4'h9;
        #1;
        checks++;
        if (outs !== 8'b1010_0000) begin
            errors++; $display("FAIL ret_only_outs got=%b exp=%b", outs, 8'b1010_0000);
        end
        tick(0, 0, 1, 1);
    endtask

    task automatic test_ret_load_use();
        idle(); D_icode = 4'h9; E_icode = 4'hB; E_dstM = 4'h4; d_srcB = 4'h4;
        #1;
        checks++;
        if (outs !== 8'b1101_0000) begin
            errors++; $display("FAIL ret_lu_outs got=%b exp=%b", outs, 8'b1101_0000);
        end
        tick(1, 0, 0, 1);
        checks++;
        if (cnts !== {exp_cyc, exp_lu, exp_mp, exp_ret}) begin
            errors++; $display("FAIL ret_lu_cnts got=%h exp=%h", cnts, {exp_cyc, exp_lu, exp_mp, exp_ret});
        end
    endtask

    task automatic test_exception();
        idle(); E_icode = 4'h6; m_stat = 2'b11;
        #1;
        checks++;
        if (outs !== 8'b0) begin
            errors++; $display("FAIL exc_run_outs got=%b exp=%b", outs, 8'b0);
        end
        tick(0, 0, 0, 1);
        m_stat = 2'b01;
        #1;
        checks++;
        if (outs !== 8'b0000_1000) begin
            errors++; $display("FAIL drain_outs got=%b exp=%b", outs, 8'b0000_1000);
        end
        tick(0, 0, 0, 1);
        W_stat = 2'b11;
        #1;
        checks++;
        if (outs !== 8'b0000_1000) begin
            errors++; $display("FAIL drain_wstat_outs got=%b exp=%b", outs, 8'b0000_1000);
        end
        tick(0, 0, 0, 1);
        // Now halted; clear status and offer a load-use to show nothing counts.
        idle(); E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3;
        #1;
        checks++;
        if (outs !== 8'b1100_0101) begin
            errors++; $display("FAIL halt_outs got=%b exp=%b", outs, 8'b1100_0101);
        end
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        checks++;
        if (cnts !== {exp_cyc, exp_lu, exp_mp, exp_ret}) begin
            errors++; $display("FAIL halt_frozen_cnts got=%h exp=%h", cnts, {exp_cyc, exp_lu, exp_mp, exp_ret});
        end
        checks++;
        if (halted !== 1'b1) begin
            errors++; $display("FAIL halt_absorbing got=%b exp=1", halted);
        end
    endtask

    task automatic test_run_to_halt();
        do_reset();
        idle(); W_stat = 2'b00;
        tick(0, 0, 0, 1);
        idle();
        #1;
        checks++;
        if (outs !== 8'b1100_0101) begin
            errors++; $display("FAIL run_to_halt_outs got=%b exp=%b", outs, 8'b1100_0101);
        end
        checks++;
        if (cnts !== {exp_cyc, exp_lu, exp_mp, exp_ret}) begin
            errors++; $display("FAIL run_to_halt_cnts got=%h exp=%h", cnts, {exp_cyc, exp_lu, exp_mp, exp_ret});
        end
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        idle(); m_stat = 2'b10;
        tick(0, 0, 0, 1);
        tick(0, 0, 0, 1);
        m_stat = 2'b01;
        #1;
        checks++;
        if (M_bubble !== 1'b1 || halted !== 1'b0) begin
            errors++; $display("FAIL pre_reset_drain got=%b exp=%b", {M_bubble, halted}, 2'b10);
        end
        #1;
        rst = 1'b1;
        #1;
        clear_exp();
        checks++;
        if (cnts !== 128'h0) begin
            errors++; $display("FAIL mid_drain_reset_cnts got=%h exp=0", cnts);
        end
        checks++;
        if (outs !== 8'b0011_1000) begin
            errors++; $display("FAIL mid_drain_reset_outs got=%b exp=%b", outs, 8'b0011_1000);
        end
        @(negedge clk);
        rst = 1'b0;
        E_icode = 4'h6;
        #1;
        checks++;
        if (outs !== 8'b0000_0010) begin
            errors++; $display("FAIL after_reset_run got=%b exp=%b", outs, 8'b0000_0010);
        end
        tick(0, 0, 0, 1);
        checks++;
        if (cnts !== {exp_cyc, exp_lu, exp_mp, exp_ret}) begin
            errors++; $display("FAIL after_reset_cnts got=%h exp=%h", cnts, {exp_cyc, exp_lu, exp_mp, exp_ret});
        end
    endtask

    task automatic test_saturation();
        do_reset();
        idle();
        for (int i = 0; i < 14; i++) tick(0, 0, 0, 1);
        checks++;
        if (s_cyc !== 4'hE) begin
            errors++; $display("FAIL sat_cyc_14 got=%h exp=%h", s_cyc, 4'hE);
        end
        for (int i = 0; i < 6; i++) tick(0, 0, 0, 1);
        checks++;
        if (s_cyc !== 4'hF) begin
            errors++; $display("FAIL sat_cyc_20 got=%h exp=%h", s_cyc, 4'hF);
        end
        checks++;
        if (cyc_cnt !== exp_cyc) begin
            errors++; $display("FAIL wide_cyc_20 got=%0d exp=%0d", cyc_cnt, exp_cyc);
        end
    endtask

    initial begin
        test_reset();
        test_opq();
        test_load_use();
        test_mispredict();
        test_ret_load_use();
        test_exception();
        test_run_to_halt();
        test_reset_mid_drain();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
